arf_frame_loader: RTL

Input sequencing and state-feedback stage that sits directly upstream of the ARF variance datapath. It collects a serial stream of 16-bit samples into an 8-sample frame and presents the frame in parallel to the datapath's eight sample inputs. It holds the two 32-bit recursive state words that drive the datapath's constant-operand adders. On frame handshake it captures the datapath's two 32-bit results, feeds them back as next-frame state and re-issues them as a registered output pulse.

---
 rtl/arf_frame_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/arf_frame_loader.sv
// arf_frame_loader
// Gathers a serial stream of samples into an 8-sample frame. The frame is
// presented in parallel to the ARF variance datapath. The loader holds the
// two recursive state words that the datapath feeds on. On the frame
// handshake it writes the datapath results back as the next state and also
// re-issues them as a one-cycle registered output pulse.
module arf_frame_loader #(
    parameter int              DW       = 16,
    parameter int              SW       = 32,
    parameter int              N        = 8,
    parameter logic [SW-1:0]   ST0_INIT = '0,
    parameter logic [SW-1:0]   ST1_INIT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          st_clr,
    output logic [DW-1:0] smp_0,
    output logic [DW-1:0] smp_1,
    output logic [DW-1:0] smp_2,
    output logic [DW-1:0] smp_3,
    output logic [DW-1:0] smp_4,
    output logic [DW-1:0] smp_5,
    output logic [DW-1:0] smp_6,
    output logic [DW-1:0] smp_7,
    output logic [SW-1:0] st_0,
    output logic [SW-1:0] st_1,
    output logic          f_valid,
    input  logic          f_ready,
    input  logic [SW-1:0] res_0,
    input  logic [SW-1:0] res_1,
    output logic          o_valid,
    output logic [SW-1:0] o_res_0,
    output logic [SW-1:0] o_res_1,
    output logic [15:0]   frame_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    state_t        state;
    logic [2:0]    idx;
    logic [DW-1:0] smp_q [N];

    // Frame storage drives the datapath sample inputs directly.
    assign smp_0 = smp_q[0];
    assign smp_1 = smp_q[1];
    assign smp_2 = smp_q[2];
    assign smp_3 = smp_q[3];
    assign smp_4 = smp_q[4];
    assign smp_5 = smp_q[5];
    assign smp_6 = smp_q[6];
    assign smp_7 = smp_q[7];

    // FILL/HOLD sequencer. s_ready and f_valid are flops that track the state,
    // so neither has a combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            s_ready   <= 1'b1;
            f_valid   <= 1'b0;
            idx       <= 3'd0;
            // NOTE: the sample store is a handful of flops, not a RAM. Clearing
            // it on reset is cheap and keeps a discarded partial frame from
            // leaking into the datapath.
            for (int i = 0; i < N; i++) smp_q[i] <= '0;
            st_0      <= ST0_INIT;
            st_1      <= ST1_INIT;
            o_valid   <= 1'b0;
            o_res_0   <= '0;
            o_res_1   <= '0;
            frame_cnt <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments only. Every flop in this block
            // samples pre-edge values. idx can therefore be read as the write
            // address while it is incremented in the same cycle.
            o_valid <= 1'b0;
            unique case (state)
                FILL: begin
                    if (s_valid) begin
                        smp_q[idx] <= s_data;
                        idx        <= idx + 3'd1;
                        if (idx == LAST_IDX) begin
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            f_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (f_ready) begin
                        st_0      <= res_0;
                        st_1      <= res_1;
                        o_res_0   <= res_0;
                        o_res_1   <= res_1;
                        o_valid   <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= FILL;
                        s_ready   <= 1'b1;
                        f_valid   <= 1'b0;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                    f_valid <= 1'b0;
                end
            endcase
            // This clear is written last so that it overrides a coinciding
            // handshake write-back. The o_res_* registers still capture the
            // results.
            if (st_clr) begin
                st_0 <= ST0_INIT;
                st_1 <= ST1_INIT;
            end
        end
    end

endmodule
